panel_input_cond: RTL and testbench

PANEL_INPUT_COND -- requirements
Module: panel_input_cond

---
 rtl/panel_pkg.sv | 25 ++
 rtl/tick_gen.sv | 58 +++++
 rtl/panel_input_cond.sv | 203 ++++++++++++++++++++
 tb/tb_panel_input_cond.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : panel_pkg
//  Description : Shared types and default timing constants for the front-panel
//                input conditioning block: button FSM state encoding and the
//                default debounce / long-press / step-tick periods.
//  Revision    : 1.0 - initial release
// ============================================================================
package panel_pkg;

  // Default timing values in clk cycles
  localparam int unsigned DEB_CYCLES_DEF  = 1_000_000;
  localparam int unsigned LONG_CYCLES_DEF = 200_000_000;
  localparam int unsigned TICK_CYCLES_DEF = 400_000_000;

  // Button conditioning FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running step-tick generator. Counts enabled clk cycles
//                and emits a registered one-cycle pulse every TICK_CYCLES of
//                them. Disabling or clearing restarts the count from zero.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                run_en    - count enable; low holds the counter at zero
//                tick_clr  - synchronous restart, wins over run_en
//                step_tick - one-cycle pulse per completed period
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import panel_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_en,
  input  logic tick_clr,
  output logic step_tick
);

  localparam int unsigned       TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0]     TCNT_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          step_tick_q, step_tick_d;

  always_comb begin
    tcnt_d      = tcnt_q;
    step_tick_d = 1'b0;
    if (tick_clr || !run_en) begin
      tcnt_d = '0;
    end else if (tcnt_q == TCNT_LAST) begin
      tcnt_d      = '0;
      step_tick_d = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q      <= '0;
      step_tick_q <= 1'b0;
    end else begin
      tcnt_q      <= tcnt_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign step_tick = step_tick_q;

endmodule
`default_nettype wire

// File: rtl/panel_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : panel_input_cond
//  Description : Front-panel input conditioning. Synchronises and debounces a
//                push-button (press / long-press / level) and a 3-bit mode
//                switch bank, and hosts the step-tick generator.
//  Ports       : clk, rst_n          - clock / async active-low reset
//                button_raw          - raw push-button, high = pressed
//                switch_raw[2:0]     - raw mode switches
//                run_en, tick_clr    - step-tick enable / restart
//                btn_press, btn_long - one-cycle press / long-hold pulses
//                btn_level           - debounced button level
//                sw_stable[2:0]      - debounced switch value
//                sw_changed          - pulse when sw_stable updates
//                step_tick           - periodic step pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_input_cond
  import panel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  input  logic [2:0] switch_raw,
  input  logic       run_en,
  input  logic       tick_clr,
  output logic       btn_press,
  output logic       btn_long,
  output logic       btn_level,
  output logic [2:0] sw_stable,
  output logic       sw_changed,
  output logic       step_tick
);

  localparam int unsigned   DW        = $clog2(DEB_CYCLES);
  localparam int unsigned   HW        = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_PRE  = HW'(LONG_CYCLES - 2);

  // --------------------------------------------------------------------------
  // Two-flop synchronisers
  // --------------------------------------------------------------------------
  logic       btn_meta_q, btn_sync_q;
  logic [2:0] sw_meta_q,  sw_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= 3'b000;
      sw_sync_q  <= 3'b000;
    end else begin
      btn_meta_q <= button_raw;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= switch_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Button FSM
  // --------------------------------------------------------------------------
  btn_state_e    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d;
  logic          long_q, long_d;
  logic          level_q, level_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d = DB_PRESS;
          dcnt_d  = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!btn_sync_q) begin
          state_d = DB_RELEASE;
          dcnt_d  = '0;
        end else if (hcnt_q != HCNT_LAST) begin
          // Saturating count: the long pulse fires only on the step into the
          // last value, so a hold never produces it twice.
          hcnt_d = hcnt_q + HW'(1);
          long_d = (hcnt_q == HCNT_PRE);
        end
      end
      DB_RELEASE: begin
        // hcnt is left untouched so a release glitch resumes the same hold
        if (btn_sync_q) begin
          state_d = HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      press_q <= press_d;
      long_q  <= long_d;
      level_q <= level_d;
    end
  end

  // --------------------------------------------------------------------------
  // Switch debounce: a candidate value must stay unchanged for a full window
  // before it replaces sw_stable; any change restarts the window.
  // --------------------------------------------------------------------------
  logic [2:0]    sw_prev_q;
  logic [2:0]    sw_stable_q, sw_stable_d;
  logic [DW-1:0] scnt_q, scnt_d;
  logic          sw_changed_q, sw_changed_d;

  always_comb begin
    sw_stable_d  = sw_stable_q;
    scnt_d       = scnt_q;
    sw_changed_d = 1'b0;
    if (sw_sync_q == sw_stable_q) begin
      scnt_d = '0;
    end else if (sw_sync_q != sw_prev_q) begin
      scnt_d = '0;
    end else if (scnt_q == DCNT_LAST) begin
      sw_stable_d  = sw_sync_q;
      sw_changed_d = 1'b1;
      scnt_d       = '0;
    end else begin
      scnt_d = scnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev_q    <= 3'b000;
      sw_stable_q  <= 3'b000;
      scnt_q       <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_prev_q    <= sw_sync_q;
      sw_stable_q  <= sw_stable_d;
      scnt_q       <= scnt_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Step tick
  // --------------------------------------------------------------------------
  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .tick_clr  (tick_clr),
    .step_tick (step_tick)
  );

  assign btn_press  = press_q;
  assign btn_long   = long_q;
  assign btn_level  = level_q;
  assign sw_stable  = sw_stable_q;
  assign sw_changed = sw_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_panel_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_panel_input_cond
//  Description : Self-checking bench for panel_input_cond with short timing
//                parameters. Step tick and switch outputs are compared every
//                cycle against a run-length / history-window model; button
//                behaviour is checked at directed points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_input_cond;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int TICK = 10;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       button_raw = 1'b0;
  logic [2:0] switch_raw = 3'b000;
  logic       run_en     = 1'b0;
  logic       tick_clr   = 1'b0;
  logic       btn_press, btn_long, btn_level, sw_changed, step_tick;
  logic [2:0] sw_stable;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observation tallies
  int press_cnt = 0, long_cnt = 0, last_press = 0, last_long = 0;
  int level_lo_cnt = 0, level_hi_cnt = 0, sw_chg_cnt = 0, tick_cnt = 0;

  // Reference model state
  int         run_len    = 0;     // consecutive enabled, uncleared edges
  logic [2:0] hist[$];            // raw switch value seen at each recent edge
  logic [2:0] exp_stable = 3'b000;

  always #5 clk = ~clk;

  panel_input_cond #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .TICK_CYCLES (TICK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_raw (button_raw),
    .switch_raw (switch_raw),
    .run_en     (run_en),
    .tick_clr   (tick_clr),
    .btn_press  (btn_press),
    .btn_long   (btn_long),
    .btn_level  (btn_level),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .step_tick  (step_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hist_clear();
    hist.delete();
    for (int i = 0; i < DEB + 3; i++) hist.push_back(3'b000);
  endtask

  // One clock edge: update the model from the inputs present at the edge,
  // then sample the DUT 1 time unit later.
  task automatic step();
    logic [2:0] v;
    bit         load;
    bit         exp_tick;
    @(posedge clk);
    cyc++;
    // Tick: pulse whenever the enabled run length is a whole number of periods
    if (!rst_n || !run_en || tick_clr) run_len = 0;
    else                               run_len++;
    exp_tick = (run_len > 0) && (run_len % TICK == 0);
    // Switches: the value reaching the debouncer lags raw by two edges; it is
    // accepted once DEB+1 consecutive edges all see the same new value.
    load = 1'b0;
    if (!rst_n) begin
      hist_clear();
      exp_stable = 3'b000;
    end else begin
      hist.push_back(switch_raw);
      if (hist.size() > DEB + 3) void'(hist.pop_front());
      v    = hist[0];
      load = (v != exp_stable);
      for (int i = 1; i <= DEB; i++) if (hist[i] != v) load = 1'b0;
      if (load) exp_stable = v;
    end
    #1;
    chk("step_tick", {31'd0, step_tick}, {31'd0, exp_tick});
    chk("sw_changed", {31'd0, sw_changed}, {31'd0, load});
    chk("sw_stable", {29'd0, sw_stable}, {29'd0, exp_stable});
    if (btn_press === 1'b1) begin press_cnt++; last_press = cyc; end
    if (btn_long === 1'b1)  begin long_cnt++;  last_long  = cyc; end
    if (btn_level === 1'b0) level_lo_cnt++;
    if (btn_level === 1'b1) level_hi_cnt++;
    if (sw_changed === 1'b1) sw_chg_cnt++;
    if (step_tick === 1'b1)  tick_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_press"}, {31'd0, btn_press}, 32'd0);
    chk({tag, "_long"},  {31'd0, btn_long},  32'd0);
    chk({tag, "_level"}, {31'd0, btn_level}, 32'd0);
    chk({tag, "_sw"},    {29'd0, sw_stable}, 32'd0);
    chk({tag, "_swchg"}, {31'd0, sw_changed}, 32'd0);
    chk({tag, "_tick"},  {31'd0, step_tick}, 32'd0);
  endtask

  initial begin
    int start, p0, l0, c0, hold;
    hist_clear();

    // ---- Reset state and quiet reset release
    run(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    run(8);
    chk("no_pulse_after_reset", press_cnt + long_cnt + sw_chg_cnt + tick_cnt, 32'd0);

    // ---- Clean press: press after DEB+3 edges, long after DEB+3+LONG-1
    start = cyc;
    button_raw = 1'b1;
    run(DEB + 2);
    chk("level_before_press", {31'd0, btn_level}, 32'd0);
    run(1);
    chk("press_pulse", {31'd0, btn_press}, 32'd1);
    chk("level_at_press", {31'd0, btn_level}, 32'd1);
    run(1);
    chk("press_one_cycle", {31'd0, btn_press}, 32'd0);
    run(60);
    chk("press_count", press_cnt, 32'd1);
    chk("press_latency", last_press - start, DEB + 3);
    chk("long_count", long_cnt, 32'd1);
    chk("long_latency", last_long - start, DEB + 3 + LONG - 1);

    // ---- Release glitch after saturation: no drop, no repeats
    level_lo_cnt = 0;
    button_raw = 1'b0;
    run(2);
    button_raw = 1'b1;
    run(30);
    chk("glitch_sat_level", level_lo_cnt, 32'd0);
    chk("glitch_sat_press", press_cnt, 32'd1);
    chk("glitch_sat_long", long_cnt, 32'd1);

    // ---- Release: level falls after DEB+3 edges
    button_raw = 1'b0;
    run(DEB + 2);
    chk("level_before_release", {31'd0, btn_level}, 32'd1);
    run(1);
    chk("level_released", {31'd0, btn_level}, 32'd0);
    run(5);

    // ---- Release glitch before the long-press point
    p0 = press_cnt;
    l0 = long_cnt;
    button_raw = 1'b1;
    run(DEB + 3);
    chk("press2_pulse", {31'd0, btn_press}, 32'd1);
    level_lo_cnt = 0;
    run(5);
    button_raw = 1'b0;
    run(2);
    button_raw = 1'b1;
    run(40);
    chk("glitch_level", level_lo_cnt, 32'd0);
    chk("glitch_press_count", press_cnt - p0, 32'd1);
    chk("glitch_long_count", long_cnt - l0, 32'd1);
    button_raw = 1'b0;
    run(DEB + 3);
    chk("glitch_released", {31'd0, btn_level}, 32'd0);
    run(5);

    // ---- Bounce: 1,0,1,0 at 2-cycle spacing never qualifies
    p0 = press_cnt;
    level_hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      button_raw = (i % 2 == 0);
      run(2);
    end
    button_raw = 1'b0;
    run(20);
    chk("bounce_press", press_cnt - p0, 32'd0);
    chk("bounce_level", level_hi_cnt, 32'd0);

    // ---- Reset mid-hold, then fresh press after DEB+3 edges
    button_raw = 1'b1;
    run(DEB + 10);
    chk("hold_before_reset", {31'd0, btn_level}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_level", {31'd0, btn_level}, 32'd0);
    run(3);
    chk_all_zero("midhold_reset");
    rst_n = 1'b1;
    p0 = press_cnt;
    run(DEB + 2);
    chk("rearm_no_early_press", press_cnt - p0, 32'd0);
    run(1);
    chk("rearm_press", {31'd0, btn_press}, 32'd1);
    button_raw = 1'b0;
    run(DEB + 8);

    // ---- Switches: clean change and a change superseded within 3 cycles
    c0 = sw_chg_cnt;
    switch_raw = 3'b101;
    run(20);
    chk("sw_101", {29'd0, sw_stable}, 32'd5);
    chk("sw_101_count", sw_chg_cnt - c0, 32'd1);
    switch_raw = 3'b000;
    run(20);
    c0 = sw_chg_cnt;
    switch_raw = 3'b101;
    run(2);
    switch_raw = 3'b110;
    run(20);
    chk("sw_110", {29'd0, sw_stable}, 32'd6);
    chk("sw_110_count", sw_chg_cnt - c0, 32'd1);

    // ---- Step tick: 35 enabled cycles, clear mid-count, disabled
    c0 = tick_cnt;
    run_en = 1'b1;
    run(35);
    chk("tick_35", tick_cnt - c0, 32'd3);
    run_en = 1'b0;
    run(1);
    run_en = 1'b1;
    run(5);
    tick_clr = 1'b1;
    run(1);
    tick_clr = 1'b0;
    run(TICK - 1);
    chk("tick_after_clr_early", {31'd0, step_tick}, 32'd0);
    run(1);
    chk("tick_after_clr", {31'd0, step_tick}, 32'd1);
    run_en = 1'b0;
    c0 = tick_cnt;
    run(30);
    chk("tick_disabled", tick_cnt - c0, 32'd0);

    // ---- Randomised switches and tick controls against the model
    hold = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        switch_raw = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 10);
      end
      hold--;
      run_en   = ($urandom_range(0, 9) != 0);
      tick_clr = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
